// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   UART transmitter that pulls bytes from a synchronous FIFO (fifo_syn) and
//   serialises them onto txd: start bit, WIDTH data bits LSB first, optional
//   even-parity bit, then STOP_BITS stop bits. Idles high.
//
//   Compile-time option: define UART_TX_PARITY_EN to add one even-parity bit
//   after the data bits. Without it the PARITY state and its logic are absent.
//
// Parameters
//   WIDTH      data bits per frame (equals the FIFO WIDTH)
//   CLK_FREQ   clk frequency in Hz
//   BAUD       line rate; BIT_CYC = CLK_FREQ / BAUD clk cycles per bit (>= 2)
//   STOP_BITS  1 or 2
//
// Ports
//   clk      in   system clock, shared with the FIFO
//   rst_n    in   asynchronous active-low reset
//   empty    in   FIFO empty flag
//   q        in   FIFO read data, valid the cycle after rd is sampled high
//   rd       out  FIFO read request, one-cycle pulse per byte
//   txd      out  serial line
//   busy     out  high whenever the transmitter is not idle
//   tx_done  out  one-cycle pulse in the cycle after the last stop-bit cycle
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int WIDTH     = 8,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             empty,
  input  logic [WIDTH-1:0] q,
  output logic             rd,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CNT_W   = $clog2(BIT_CYC) + 1;
  // Bit index counts data bits and, in STOP, the stop bits.
  localparam int IDX_W   = $clog2(WIDTH + 1) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic             tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q,  parity_d;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    // Baud counter free-runs inside a frame and wraps on each bit boundary.
    cnt_d     = bit_end ? '0 : cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) state_d = S_FETCH;
      end
      S_FETCH: begin
        cnt_d   = '0;
        idx_d   = '0;
        shift_d = q;
`ifdef UART_TX_PARITY_EN
        // Parity is taken from the captured byte, since shift_q drains.
        parity_d = ^q;
`endif
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d     = '0;
            tx_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // rd is gated by rst_n: state sits in IDLE during reset, and the FIFO
    // must not be popped while the transmitter is held.
    rd      = 1'b0;
    txd     = 1'b1;
    busy    = (state_q != S_IDLE);
    tx_done = tx_done_q;
    unique case (state_q)
      S_IDLE:   rd  = rst_n & ~empty;
      S_START:  txd = 1'b0;
      S_DATA:   txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd = parity_q;
`endif
      default:  txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Bench for fifo_uart_tx at BIT_CYC = 10. A queue-backed FIFO model feeds the
//   main instance; a line monitor decodes every frame and compares it with the
//   scoreboard of pushed bytes. A second instance with STOP_BITS=2 is driven
//   by hand. Honours UART_TX_PARITY_EN for expected frame shapes.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int BIT_CYC = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS  = 1 + 8 + PAR_BITS + 1;
  localparam int FRAME       = FRAME_BITS * BIT_CYC;
  localparam int FRAME2_BITS = 1 + 8 + PAR_BITS + 2;
  localparam int FRAME2      = FRAME2_BITS * BIT_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] q = '0;
  logic       rd, txd, busy, tx_done;

  logic       empty2 = 1'b1;
  logic [7:0] q2 = '0;
  logic       rd2, txd2, busy2, tx_done2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int frames_seen = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sb[$];

  fifo_uart_tx #(.WIDTH(8), .CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .q(q),
    .rd(rd), .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  fifo_uart_tx #(.WIDTH(8), .CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .empty(empty2), .q(q2),
    .rd(rd2), .txd(txd2), .busy(busy2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd === 1'b1) rd_cnt <= rd_cnt + 1;

  // FIFO model: registered q, empty reflects the queue as of the last edge.
  always @(posedge clk) begin
    if (rd === 1'b1 && fifo_q.size() > 0) q <= fifo_q.pop_front();
    empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line monitor / scoreboard consumer (main instance)
  // ---------------------------------------------------------------------------
  logic       mon_abort;
  logic       mon_ok;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rst_n !== 1'b1) mon_abort = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        mon_abort = 1'b0;
        mon_ok    = 1'b1;
        mon_wait(BIT_CYC / 2);
        if (txd !== 1'b0) mon_ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
          mon_wait(BIT_CYC);
          mon_byte[b] = txd;
        end
`ifdef UART_TX_PARITY_EN
        mon_wait(BIT_CYC);
        if (txd !== ^mon_byte) mon_ok = 1'b0;
`endif
        mon_wait(BIT_CYC);
        if (txd !== 1'b1) mon_ok = 1'b0;
        if (!mon_abort) begin
          frames_seen++;
          check("sb frame expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            check("sb byte", 32'(mon_byte), 32'(mon_exp));
            check("sb framing", 32'(mon_ok), 1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Single-frame sequence on the main instance
  // ---------------------------------------------------------------------------
  task automatic run_frame(input logic [7:0] data, input logic par, input string tag);
    logic [FRAME_BITS-1:0] eb;
    int   rd0, bad;
    logic got_start;
    eb      = '1;
    eb[0]   = 1'b0;
    eb[8:1] = data;
`ifdef UART_TX_PARITY_EN
    eb[9]   = par;
`else
    if (par === 1'bx) eb = '1;  // par only shapes frames in the parity build
`endif
    rd0 = rd_cnt;
    @(negedge clk);
    fifo_q.push_back(data);
    sb.push_back(data);
    got_start = 1'b0;
    for (int i = 0; i < 20 && !got_start; i++) begin
      @(negedge clk);
      if (txd === 1'b0) got_start = 1'b1;
    end
    check({tag, " start seen"}, 32'(got_start), 1);
    if (!got_start) return;
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (txd !== eb[i / BIT_CYC]) bad++;
      if (tx_done !== 1'b0 || busy !== 1'b1) bad++;
    end
    check({tag, " bad frame cycles"}, 32'(bad), 0);
    @(negedge clk);
    check({tag, " tx_done/busy/txd at FRAME"}, {tx_done, busy, txd}, 3'b101);
    @(negedge clk);
    check({tag, " tx_done one pulse"}, 32'(tx_done), 0);
    check({tag, " rd pulses"}, 32'(rd_cnt - rd0), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[5];
  logic [FRAME2_BITS-1:0] eb2;
  int   bad, stop_hi, rd0, nrd;
  int   rd_t[3];
  logic seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'h7E, 1'b0};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'hFF, 1'b0};

    // --- reset state and idle with empty FIFO ---
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rd/txd/busy/tx_done", {rd, txd, busy, tx_done}, 4'b0100);
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({rd, txd, busy, tx_done} !== 4'b0100) bad++;
      if ({rd2, txd2, busy2, tx_done2} !== 4'b0100) bad++;
    end
    check("idle 50 cycles bad", 32'(bad), 0);

    // --- table-driven single frames ---
    foreach (vecs[i]) run_frame(vecs[i].data, vecs[i].par, $sformatf("vec%0d", i));

    // --- back-to-back bytes ---
    rd0 = rd_cnt;
    @(negedge clk);
    fifo_q.push_back(8'h00); sb.push_back(8'h00);
    fifo_q.push_back(8'hFF); sb.push_back(8'hFF);
    fifo_q.push_back(8'h3C); sb.push_back(8'h3C);
    nrd = 0;
    for (int i = 0; i < 4 * (FRAME + 2) && nrd < 3; i++) begin
      @(negedge clk);
      if (rd === 1'b1) begin
        rd_t[nrd] = cyc;
        nrd++;
      end
    end
    check("b2b rd pulses", 32'(nrd), 3);
    if (nrd == 3) begin
      check("b2b spacing 1", 32'(rd_t[1] - rd_t[0]), 32'(FRAME + 2));
      check("b2b spacing 2", 32'(rd_t[2] - rd_t[1]), 32'(FRAME + 2));
      @(negedge clk);
      check("b2b empty after third rd", 32'(empty), 1);
    end
    seen = 1'b0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy === 1'b0) seen = 1'b1;
    end
    check("b2b drained and idle", 32'(seen), 1);
    check("b2b rd total", 32'(rd_cnt - rd0), 3);

    // --- two stop bits (second instance, hand-driven FIFO port) ---
    eb2      = '1;
    eb2[0]   = 1'b0;
    eb2[8:1] = 8'h55;
`ifdef UART_TX_PARITY_EN
    eb2[9]   = 1'b0;
`endif
    @(negedge clk);
    empty2 = 1'b0;
    #1 check("stop2 rd in IDLE", 32'(rd2), 1);
    @(negedge clk);
    check("stop2 no rd in FETCH", {busy2, rd2}, 2'b10);
    empty2 = 1'b1;
    q2     = 8'h55;
    @(negedge clk);
    bad = 0;
    stop_hi = 0;
    for (int i = 0; i < FRAME2; i++) begin
      if (i > 0) @(negedge clk);
      if (txd2 !== eb2[i / BIT_CYC] || busy2 !== 1'b1 || tx_done2 !== 1'b0) bad++;
      if (i >= (FRAME2_BITS - 2) * BIT_CYC && txd2 === 1'b1) stop_hi++;
    end
    check("stop2 bad frame cycles", 32'(bad), 0);
    check("stop2 stop level cycles", 32'(stop_hi), 20);
    @(negedge clk);
    check("stop2 tx_done at FRAME2", {tx_done2, busy2, txd2}, 3'b101);

    // --- reset in the middle of DATA ---
    rd0 = rd_cnt;
    @(negedge clk);
    fifo_q.push_back(8'h81);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (txd === 1'b0) seen = 1'b1;
    end
    check("rst start seen", 32'(seen), 1);
    repeat (35) @(negedge clk);
    check("rst busy before reset", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check("rst txd/busy at once", {txd, busy, rd}, 3'b100);
    fifo_q.push_back(8'h42);
    sb.push_back(8'h42);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({rd, txd, busy, tx_done} !== 4'b0100) bad++;
    end
    check("rst held outputs bad", 32'(bad), 0);
    check("rst single pop of 0x81", 32'(rd_cnt - rd0), 1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy === 1'b0) seen = 1'b1;
    end
    check("rst next byte sent", 32'(seen), 1);
    check("rst rd total", 32'(rd_cnt - rd0), 2);
    check("rst fifo drained", 32'(fifo_q.size()), 0);

    repeat (5) @(negedge clk);
    check("frames decoded", 32'(frames_seen), 9);
    check("scoreboard empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
